// File: rtl/zz_pkg.sv
// Shared widths, FSM state encoding and owner tags for the Ram1 arbiter.
package zz_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned CPU_ADDR_W = 16;
    localparam int unsigned RAM_ADDR_W = 18;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrSetup,
        StWrPulse,
        StWrHold
    } state_e;

    typedef enum logic {
        OwnerIf,
        OwnerMem
    } owner_e;

endpackage

// File: rtl/ram1_arbiter_if.sv
// CPU-side fetch and data request/response bundle for the Ram1 arbiter.
interface ram1_arbiter_if;
    import zz_pkg::*;

    logic                  if_req;
    logic [CPU_ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ready;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [CPU_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;
    logic                  stall_if;

    modport master (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, stall_if
    );

    modport slave (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, stall_if
    );

endinterface

// File: rtl/ram1_iobuf.sv
// Tristate pad driver for the bidirectional SRAM data bus.
module ram1_iobuf
    import zz_pkg::*;
(
    input  logic [DATA_W-1:0] out_data_i,
    input  logic              out_en_i,
    output logic [DATA_W-1:0] in_data_o,
    inout  wire  [DATA_W-1:0] pad_io
);

    assign pad_io    = out_en_i ? out_data_i : 'z;
    assign in_data_o = pad_io;

endmodule

// File: rtl/ram1_arbiter.sv
// Arbitrates fetch and MEM-stage accesses onto the single-port asynchronous SRAM Ram1.
// Writes use setup/pulse/hold so address and data bracket the one-cycle WE low pulse.
module ram1_arbiter
    import zz_pkg::*;
#(
    parameter logic [1:0] ADDR_HI = 2'b00
) (
    input  logic                  clk,
    input  logic                  rst,
    ram1_arbiter_if.slave         bus,
    output logic [RAM_ADDR_W-1:0] Ram1Addr,
    inout  wire  [DATA_W-1:0]     Ram1Data,
    output logic                  Ram1OE,
    output logic                  Ram1WE,
    output logic                  Ram1EN
);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [CPU_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;
    logic                  en_q, en_d, oe_q, oe_d, we_q, we_d, drive_q, drive_d;
    logic                  if_ready_q, if_ready_d, mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0]     pad_rdata;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        en_d        = en_q;
        oe_d        = oe_q;
        we_d        = we_q;
        drive_d     = drive_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A simultaneous mem_rd is ignored when mem_wr is high.
                if (bus.mem_wr) begin
                    state_d = StWrSetup;
                    owner_d = OwnerMem;
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    en_d    = 1'b0;
                    drive_d = 1'b1;
                end else if (bus.mem_rd) begin
                    state_d = StRead;
                    owner_d = OwnerMem;
                    addr_d  = bus.mem_addr;
                    en_d    = 1'b0;
                    oe_d    = 1'b0;
                end else if (bus.if_req) begin
                    state_d = StRead;
                    owner_d = OwnerIf;
                    addr_d  = bus.if_addr;
                    en_d    = 1'b0;
                    oe_d    = 1'b0;
                end
            end
            StRead: begin
                if (owner_q == OwnerMem) begin
                    mem_rdata_d = pad_rdata;
                    mem_ready_d = 1'b1;
                end else begin
                    if_rdata_d = pad_rdata;
                    if_ready_d = 1'b1;
                end
                state_d = StIdle;
                en_d    = 1'b1;
                oe_d    = 1'b1;
            end
            StWrSetup: begin
                state_d = StWrPulse;
                we_d    = 1'b0;
            end
            StWrPulse: begin
                state_d = StWrHold;
                we_d    = 1'b1;
            end
            StWrHold: begin
                state_d     = StIdle;
                en_d        = 1'b1;
                drive_d     = 1'b0;
                mem_ready_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
                en_d    = 1'b1;
                oe_d    = 1'b1;
                we_d    = 1'b1;
                drive_d = 1'b0;
            end
        endcase
    end

    // Strobes are flops so reset releases WE immediately, abandoning any write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnerIf;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            en_q        <= 1'b1;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            drive_q     <= 1'b0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            en_q        <= en_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            drive_q     <= drive_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    ram1_iobuf u_iobuf (
        .out_data_i (wdata_q),
        .out_en_i   (drive_q),
        .in_data_o  (pad_rdata),
        .pad_io     (Ram1Data)
    );

    assign Ram1Addr      = {ADDR_HI, addr_q};
    assign Ram1EN        = en_q;
    assign Ram1OE        = oe_q;
    assign Ram1WE        = we_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.stall_if  = bus.if_req & ~if_ready_q;

endmodule

// File: tb/tb_ram1_arbiter.sv
// Directed bench for ram1_arbiter with an async SRAM model and a transaction-level reference.
module tb_ram1_arbiter;

    localparam logic [1:0] TbAddrHi = 2'b00;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] ram1_addr;
    wire  [15:0] ram1_data;
    logic        ram1_oe, ram1_we, ram1_en;

    ram1_arbiter_if bus ();

    ram1_arbiter #(
        .ADDR_HI (TbAddrHi)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .Ram1Addr (ram1_addr),
        .Ram1Data (ram1_data),
        .Ram1OE   (ram1_oe),
        .Ram1WE   (ram1_we),
        .Ram1EN   (ram1_en)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return a ^ 16'h6C00;
    endfunction

    // Asynchronous SRAM: drives data while selected and output-enabled, stores while WE is low.
    logic [15:0] sram  [0:65535];
    logic [15:0] m_mem [0:65535];

    assign ram1_data = (!ram1_en && !ram1_oe) ? sram[ram1_addr[15:0]] : 16'hzzzz;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram[i]  = init_word(16'(i));
            m_mem[i] = init_word(16'(i));
        end
        forever begin
            @(negedge clk);
            if (!ram1_en && !ram1_we) sram[ram1_addr[15:0]] = ram1_data;
        end
    end

    // Reference: one transaction at a time; phase counts cycles since the grant edge.
    bit          m_busy, m_write, m_own_mem;
    int          m_phase;
    logic [15:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
    bit          m_rdy_if, m_rdy_mem;

    initial begin
        bit e_en, e_oe, e_we, e_drv, n_rdy_if, n_rdy_mem;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_busy = 0; m_phase = 0; m_addr = '0; m_if_rdata = '0; m_mem_rdata = '0;
                m_rdy_if = 0; m_rdy_mem = 0;
            end
            e_en = 1; e_oe = 1; e_we = 1; e_drv = 0;
            if (m_busy) begin
                e_en = 0;
                if (m_write) begin
                    e_drv = 1;
                    e_we  = (m_phase != 2);
                end else begin
                    e_oe = 0;
                end
            end
            chk("m_en", 32'(ram1_en), 32'(e_en));
            chk("m_oe", 32'(ram1_oe), 32'(e_oe));
            chk("m_we", 32'(ram1_we), 32'(e_we));
            chk("m_addr", 32'(ram1_addr), 32'({TbAddrHi, m_addr}));
            chk("m_if_ready", 32'(bus.if_ready), 32'(m_rdy_if));
            chk("m_mem_ready", 32'(bus.mem_ready), 32'(m_rdy_mem));
            chk("m_if_rdata", 32'(bus.if_rdata), 32'(m_if_rdata));
            chk("m_mem_rdata", 32'(bus.mem_rdata), 32'(m_mem_rdata));
            chk("m_stall_if", 32'(bus.stall_if), 32'(bus.if_req & ~m_rdy_if));
            if (e_drv) chk("m_wdata_bus", 32'(ram1_data), 32'(m_wdata));
            if (rst) begin
                n_rdy_if = 0; n_rdy_mem = 0;
                if (m_busy) begin
                    if (!m_write && m_phase == 1) begin
                        if (m_own_mem) begin
                            m_mem_rdata = m_mem[m_addr]; n_rdy_mem = 1;
                        end else begin
                            m_if_rdata = m_mem[m_addr]; n_rdy_if = 1;
                        end
                        m_busy = 0;
                    end else if (m_write && m_phase == 3) begin
                        m_mem[m_addr] = m_wdata; n_rdy_mem = 1; m_busy = 0;
                    end else begin
                        m_phase++;
                    end
                end else if (bus.mem_wr || bus.mem_rd || bus.if_req) begin
                    m_busy = 1; m_phase = 1;
                    m_write   = bus.mem_wr;
                    m_own_mem = bus.mem_wr || bus.mem_rd;
                    m_addr    = m_own_mem ? bus.mem_addr : bus.if_addr;
                    m_wdata   = bus.mem_wdata;
                end
                m_rdy_if = n_rdy_if; m_rdy_mem = n_rdy_mem;
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.if_req = 0; bus.if_addr = '0;
        bus.mem_rd = 0; bus.mem_wr = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
        repeat (3) step();
        chk("rst_en", 32'(ram1_en), 1);
        chk("rst_oe", 32'(ram1_oe), 1);
        chk("rst_we", 32'(ram1_we), 1);
        chk("rst_addr", 32'(ram1_addr), 0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 0);
        rst = 1'b1;
        step();

        // Fetch of word 4
        bus.if_req = 1; bus.if_addr = 16'h0004;
        #1 chk("fetch_stall_c0", 32'(bus.stall_if), 1);
        step();
        chk("fetch_addr_c1", 32'(ram1_addr), 32'h00004);
        chk("fetch_oe_c1", 32'(ram1_oe), 0);
        chk("fetch_ready_c1", 32'(bus.if_ready), 0);
        step();
        chk("fetch_ready_c2", 32'(bus.if_ready), 1);
        chk("fetch_rdata_c2", 32'(bus.if_rdata), 32'h6C04);
        chk("fetch_oe_c2", 32'(ram1_oe), 1);
        bus.if_req = 0;
        step();
        chk("fetch_ready_c3", 32'(bus.if_ready), 0);
        chk("fetch_hold_c3", 32'(bus.if_rdata), 32'h6C04);

        // Store 0x00FF to 0x8000
        bus.mem_wr = 1; bus.mem_addr = 16'h8000; bus.mem_wdata = 16'h00FF;
        step();
        chk("store_we_c1", 32'(ram1_we), 1);
        chk("store_data_c1", 32'(ram1_data), 32'h00FF);
        step();
        chk("store_we_c2", 32'(ram1_we), 0);
        step();
        chk("store_we_c3", 32'(ram1_we), 1);
        chk("store_data_c3", 32'(ram1_data), 32'h00FF);
        chk("store_ready_c3", 32'(bus.mem_ready), 0);
        step();
        chk("store_ready_c4", 32'(bus.mem_ready), 1);
        chk("store_sram", 32'(sram[16'h8000]), 32'h00FF);
        bus.mem_wr = 0;
        step();

        // Fetch and load together: load first, fetch stalls
        bus.if_req = 1; bus.if_addr = 16'h0010; bus.mem_rd = 1; bus.mem_addr = 16'h0020;
        step();
        chk("conf_addr_c1", 32'(ram1_addr), 32'h00020);
        step();
        chk("conf_mready_c2", 32'(bus.mem_ready), 1);
        chk("conf_mrdata_c2", 32'(bus.mem_rdata), 32'h6C20);
        chk("conf_stall_c2", 32'(bus.stall_if), 1);
        bus.mem_rd = 0;
        step();
        chk("conf_addr_c3", 32'(ram1_addr), 32'h00010);
        chk("conf_stall_c3", 32'(bus.stall_if), 1);
        step();
        chk("conf_iready_c4", 32'(bus.if_ready), 1);
        chk("conf_irdata_c4", 32'(bus.if_rdata), 32'h6C10);
        chk("conf_stall_c4", 32'(bus.stall_if), 0);
        bus.if_req = 0;
        step();

        // Back-to-back loads with no idle gap
        bus.mem_rd = 1; bus.mem_addr = 16'h0001;
        step(); step();
        chk("b2b_ready_c2", 32'(bus.mem_ready), 1);
        chk("b2b_rdata_c2", 32'(bus.mem_rdata), 32'h6C01);
        bus.mem_addr = 16'h0002;
        step();
        chk("b2b_oe_c3", 32'(ram1_oe), 0);
        chk("b2b_ready_c3", 32'(bus.mem_ready), 0);
        step();
        chk("b2b_ready_c4", 32'(bus.mem_ready), 1);
        chk("b2b_rdata_c4", 32'(bus.mem_rdata), 32'h6C02);
        bus.mem_rd = 0;
        step();

        // Read and write together: write only, OE never asserted
        bus.mem_rd = 1; bus.mem_wr = 1; bus.mem_addr = 16'h0030; bus.mem_wdata = 16'hBEEF;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("both_oe", 32'(ram1_oe), 1);
        end
        chk("both_ready_c4", 32'(bus.mem_ready), 1);
        chk("both_rdata_kept", 32'(bus.mem_rdata), 32'h6C02);
        chk("both_sram", 32'(sram[16'h0030]), 32'hBEEF);
        bus.mem_rd = 0; bus.mem_wr = 0;
        step();

        // Fetch request dropped mid-transaction still completes
        bus.if_req = 1; bus.if_addr = 16'h0050;
        step();
        bus.if_req = 0;
        step();
        chk("drop_ready_c2", 32'(bus.if_ready), 1);
        chk("drop_rdata_c2", 32'(bus.if_rdata), 32'h6C50);
        step();

        // Reset during the WE pulse abandons the write
        bus.mem_wr = 1; bus.mem_addr = 16'h0040; bus.mem_wdata = 16'h1234;
        step(); step();
        chk("abort_we_c2", 32'(ram1_we), 0);
        #2 rst = 1'b0;
        #1;
        chk("abort_we_async", 32'(ram1_we), 1);
        chk("abort_en_async", 32'(ram1_en), 1);
        chk("abort_ready", 32'(bus.mem_ready), 0);
        chk("abort_rdata_clr", 32'(bus.mem_rdata), 0);
        bus.mem_wr = 0;
        step();
        chk("abort_ready_after", 32'(bus.mem_ready), 0);
        rst = 1'b1;
        step();
        bus.mem_rd = 1; bus.mem_addr = 16'h0040;
        step(); step();
        chk("abort_read_ready", 32'(bus.mem_ready), 1);
        chk("abort_read_old", 32'(bus.mem_rdata), 32'h6C40);
        bus.mem_rd = 0;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
